// File: rtl/cpu_ctrl_pkg.sv
// Shared constants, state encodings and the registered-output bundle
// for the CPU run controller.
package cpu_ctrl_pkg;

  localparam int unsigned WORD_W           = 32;
  localparam int unsigned DRAIN_CYCLES_DEF = 4;
  localparam int unsigned RD_LAT_DEF       = 1;

  localparam logic LD_DST_IMEM = 1'b0;
  localparam logic LD_DST_DMEM = 1'b1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef struct packed {
    logic              ld_ready;
    logic [WORD_W-1:0] addr_ext;
    logic [WORD_W-1:0] wdata_ext;
    logic              wen_ext;
    logic              ren_ext;
    logic [WORD_W-1:0] addr_ext_2;
    logic [WORD_W-1:0] wdata_ext_2;
    logic              wen_ext_2;
    logic              ren_ext_2;
    logic              cpu_enable;
    logic              cpu_rst_n;
    logic              busy;
    logic              done;
    logic              timeout;
    logic              rd_valid;
    logic [WORD_W-1:0] rd_data;
  } ctrl_out_t;

endpackage

// File: rtl/reg_arstn_en.sv
// Generic register with asynchronous active-low reset to zero and load enable.
module reg_arstn_en #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/run_counter.sv
// Saturating cycle counter with synchronous clear, count enable and a
// combinational "last budgeted cycle" compare against a limit (0 = none).
module run_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         limit_hit_c
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count       = count_q;
  assign limit_hit_c = (limit != '0) && (count_q == (limit - W'(1)));

endmodule

// File: rtl/cpu_run_ctrl.sv
// Sequences the CPU through program load, execution, pipeline drain and
// data-memory readback; all outputs come from one registered bundle.
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned IMEM_ADDR_W  = 9,
  parameter int unsigned DMEM_ADDR_W  = 10,
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int unsigned RD_LAT       = RD_LAT_DEF
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        start,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_data,
  input  logic        ld_dst,
  input  logic        ld_last,
  input  logic        halt,
  input  logic [31:0] cycle_limit,
  input  logic        rd_req,
  input  logic [31:0] rd_addr,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  input  logic [31:0] rdata_ext_2,
  output logic [31:0] addr_ext,
  output logic [31:0] wdata_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] addr_ext_2,
  output logic [31:0] wdata_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic        cpu_enable,
  output logic        cpu_rst_n,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [31:0] cycle_count
);

  localparam int unsigned DRN_W = $clog2(DRAIN_CYCLES + 1);
  localparam int unsigned LAT_W = $clog2(RD_LAT + 1);
  localparam int unsigned OUT_W = $bits(ctrl_out_t);

  logic [2:0]             state_q, state_d;
  logic [IMEM_ADDR_W-1:0] imem_cnt_q, imem_cnt_d;
  logic [DMEM_ADDR_W-1:0] dmem_cnt_q, dmem_cnt_d;
  logic [DRN_W-1:0]       drain_cnt_q, drain_cnt_d;
  logic                   rd_pend_q, rd_pend_d;
  logic [LAT_W-1:0]       rd_lat_q, rd_lat_d;
  ctrl_out_t              o_q, o_d;

  logic ld_acc;
  logic cnt_clr;
  logic cnt_en;
  logic limit_hit_c;

  assign ld_acc = (state_q == ST_LOAD) && o_q.ld_ready && ld_valid;
  assign cnt_en = (state_q == ST_RUN) || (state_q == ST_DRAIN);

  run_counter #(.W(WORD_W)) u_run_counter (
    .clk         (clk),
    .arst_n      (arst_n),
    .clr         (cnt_clr),
    .en          (cnt_en),
    .limit       (cycle_limit),
    .count       (cycle_count),
    .limit_hit_c (limit_hit_c)
  );

  // Next state plus the next value of every registered output.
  always_comb begin
    state_d     = state_q;
    imem_cnt_d  = imem_cnt_q;
    dmem_cnt_d  = dmem_cnt_q;
    drain_cnt_d = drain_cnt_q;
    rd_pend_d   = rd_pend_q;
    rd_lat_d    = rd_lat_q;
    cnt_clr     = 1'b0;
    o_d           = o_q;
    o_d.wen_ext   = 1'b0;
    o_d.ren_ext   = 1'b0;
    o_d.wen_ext_2 = 1'b0;
    o_d.ren_ext_2 = 1'b0;
    o_d.rd_valid  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_LOAD;
          imem_cnt_d  = '0;
          dmem_cnt_d  = '0;
          cnt_clr     = 1'b1;
          o_d.timeout = 1'b0;
        end
      end
      ST_LOAD: begin
        if (ld_acc) begin
          case (ld_dst)
            LD_DST_IMEM: begin
              o_d.wen_ext   = 1'b1;
              o_d.addr_ext  = WORD_W'({imem_cnt_q, 2'b00});
              o_d.wdata_ext = ld_data;
              imem_cnt_d    = imem_cnt_q + IMEM_ADDR_W'(1);
            end
            LD_DST_DMEM: begin
              o_d.wen_ext_2   = 1'b1;
              o_d.addr_ext_2  = WORD_W'({dmem_cnt_q, 2'b00});
              o_d.wdata_ext_2 = ld_data;
              dmem_cnt_d      = dmem_cnt_q + DMEM_ADDR_W'(1);
            end
          endcase
        end else if (!o_q.ld_ready) begin
          // Last beat's write has retired; release the CPU.
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (halt) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = '0;
        end else if (limit_hit_c) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = '0;
          o_d.timeout = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == DRN_W'(DRAIN_CYCLES - 1)) begin
          state_d = ST_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + DRN_W'(1);
        end
      end
      ST_DONE: begin
        if (start) begin
          state_d     = ST_LOAD;
          imem_cnt_d  = '0;
          dmem_cnt_d  = '0;
          cnt_clr     = 1'b1;
          o_d.timeout = 1'b0;
          rd_pend_d   = 1'b0;
        end else if (rd_pend_q) begin
          if (rd_lat_q == LAT_W'(RD_LAT - 1)) begin
            o_d.rd_valid = 1'b1;
            o_d.rd_data  = rdata_ext_2;
            rd_pend_d    = 1'b0;
          end else begin
            rd_lat_d = rd_lat_q + LAT_W'(1);
          end
        end else if (rd_req) begin
          o_d.ren_ext_2  = 1'b1;
          o_d.addr_ext_2 = rd_addr;
          rd_pend_d      = 1'b1;
          rd_lat_d       = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    o_d.ld_ready   = (state_d == ST_LOAD) && !(ld_acc && ld_last);
    o_d.cpu_enable = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    o_d.cpu_rst_n  = (state_d == ST_RUN) || (state_d == ST_DRAIN) || (state_d == ST_DONE);
    o_d.busy       = (state_d == ST_LOAD) || (state_d == ST_RUN) || (state_d == ST_DRAIN);
    o_d.done       = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= ST_IDLE;
      imem_cnt_q  <= '0;
      dmem_cnt_q  <= '0;
      drain_cnt_q <= '0;
      rd_pend_q   <= 1'b0;
      rd_lat_q    <= '0;
    end else begin
      state_q     <= state_d;
      imem_cnt_q  <= imem_cnt_d;
      dmem_cnt_q  <= dmem_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      rd_pend_q   <= rd_pend_d;
      rd_lat_q    <= rd_lat_d;
    end
  end

  reg_arstn_en #(.W(OUT_W)) u_out_reg (
    .clk    (clk),
    .arst_n (arst_n),
    .en     (1'b1),
    .d      (o_d),
    .q      (o_q)
  );

  assign ld_ready    = o_q.ld_ready;
  assign addr_ext    = o_q.addr_ext;
  assign wdata_ext   = o_q.wdata_ext;
  assign wen_ext     = o_q.wen_ext;
  assign ren_ext     = o_q.ren_ext;
  assign addr_ext_2  = o_q.addr_ext_2;
  assign wdata_ext_2 = o_q.wdata_ext_2;
  assign wen_ext_2   = o_q.wen_ext_2;
  assign ren_ext_2   = o_q.ren_ext_2;
  assign cpu_enable  = o_q.cpu_enable;
  assign cpu_rst_n   = o_q.cpu_rst_n;
  assign busy        = o_q.busy;
  assign done        = o_q.done;
  assign timeout     = o_q.timeout;
  assign rd_valid    = o_q.rd_valid;
  assign rd_data     = o_q.rd_data;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: load, run/halt, timeout, readback, reset.
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        start, ld_valid, ld_dst, ld_last, halt, rd_req;
  logic [31:0] ld_data, cycle_limit, rd_addr, rdata_ext_2;
  logic        ld_ready, rd_valid, wen_ext, ren_ext, wen_ext_2, ren_ext_2;
  logic        cpu_enable, cpu_rst_n, busy, done, timeout;
  logic [31:0] rd_data, addr_ext, wdata_ext, addr_ext_2, wdata_ext_2, cycle_count;
  logic [31:0] dmem0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .start       (start),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_data     (ld_data),
    .ld_dst      (ld_dst),
    .ld_last     (ld_last),
    .halt        (halt),
    .cycle_limit (cycle_limit),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .rdata_ext_2 (rdata_ext_2),
    .addr_ext    (addr_ext),
    .wdata_ext   (wdata_ext),
    .wen_ext     (wen_ext),
    .ren_ext     (ren_ext),
    .addr_ext_2  (addr_ext_2),
    .wdata_ext_2 (wdata_ext_2),
    .wen_ext_2   (wen_ext_2),
    .ren_ext_2   (ren_ext_2),
    .cpu_enable  (cpu_enable),
    .cpu_rst_n   (cpu_rst_n),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .cycle_count (cycle_count)
  );

  // Small data-memory model: word 0 is writable, byte address 0x10 holds a constant.
  always @(posedge clk) begin
    if (wen_ext_2 && addr_ext_2 == 32'h0) dmem0 <= wdata_ext_2;
  end
  assign rdata_ext_2 = (addr_ext_2 == 32'h10) ? 32'hDEADBEEF :
                       (addr_ext_2 == 32'h0)  ? dmem0 : 32'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_beat(input logic dst, input logic [31:0] data, input logic last,
                           input logic [31:0] exp_addr);
    ld_valid = 1'b1;
    ld_dst   = dst;
    ld_data  = data;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    if (dst == 1'b0) begin
      chk("imem_wen", 32'(wen_ext), 32'd1);
      chk("imem_addr", addr_ext, exp_addr);
      chk("imem_wdata", wdata_ext, data);
      chk("imem_no_dwen", 32'(wen_ext_2), 32'd0);
    end else begin
      chk("dmem_wen", 32'(wen_ext_2), 32'd1);
      chk("dmem_addr", addr_ext_2, exp_addr);
      chk("dmem_wdata", wdata_ext_2, data);
      chk("dmem_no_iwen", 32'(wen_ext), 32'd0);
    end
    chk("ren_ext", 32'(ren_ext), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, 32'({ld_ready, wen_ext, ren_ext, wen_ext_2, ren_ext_2, cpu_enable,
                  cpu_rst_n, busy, done, timeout, rd_valid}), 32'd0);
    chk({tag, "_buses"}, addr_ext | addr_ext_2 | wdata_ext | wdata_ext_2 | rd_data, 32'd0);
    chk({tag, "_count"}, cycle_count, 32'd0);
  endtask

  initial begin
    arst_n = 1'b0; start = 1'b0; ld_valid = 1'b0; ld_dst = 1'b0; ld_last = 1'b0;
    halt = 1'b0; rd_req = 1'b0; ld_data = '0; cycle_limit = '0; rd_addr = '0;
    repeat (2) tick();
    chk_all_zero("reset");
    arst_n = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // Three imem beats, halt at RUN cycle 10
    start = 1'b1; tick(); start = 1'b0;
    chk("load_ready", 32'(ld_ready), 32'd1);
    chk("load_busy", 32'(busy), 32'd1);
    chk("load_cpu_rst", 32'(cpu_rst_n), 32'd0);
    load_beat(1'b0, 32'h20010005, 1'b0, 32'd0);
    load_beat(1'b0, 32'h20020007, 1'b0, 32'd4);
    load_beat(1'b0, 32'h00221820, 1'b1, 32'd8);
    chk("last_ready_drop", 32'(ld_ready), 32'd0);
    chk("last_enable_low", 32'(cpu_enable), 32'd0);
    tick();
    chk("run_enable", 32'(cpu_enable), 32'd1);
    chk("run_cpu_rst", 32'(cpu_rst_n), 32'd1);
    chk("run_no_wen", 32'(wen_ext), 32'd0);
    chk("run_count0", cycle_count, 32'd0);
    repeat (9) tick();
    halt = 1'b1; tick(); halt = 1'b0;
    chk("halt_count", cycle_count, 32'd10);
    chk("halt_enable", 32'(cpu_enable), 32'd1);
    repeat (3) tick();
    chk("drain_enable", 32'(cpu_enable), 32'd1);
    chk("drain_done", 32'(done), 32'd0);
    tick();
    chk("done_enable", 32'(cpu_enable), 32'd0);
    chk("done_flag", 32'(done), 32'd1);
    chk("done_timeout", 32'(timeout), 32'd0);
    chk("done_count", cycle_count, 32'd14);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_cpu_rst", 32'(cpu_rst_n), 32'd1);

    // Readback with a repeated request while pending
    rd_addr = 32'h10; rd_req = 1'b1; tick();
    chk("rd_ren", 32'(ren_ext_2), 32'd1);
    chk("rd_addr", addr_ext_2, 32'h10);
    chk("rd_valid_early", 32'(rd_valid), 32'd0);
    tick();
    chk("rd_valid", 32'(rd_valid), 32'd1);
    chk("rd_data", rd_data, 32'hDEADBEEF);
    chk("rd_ren_ignored", 32'(ren_ext_2), 32'd0);
    rd_req = 1'b0; tick();
    chk("rd_valid_pulse", 32'(rd_valid), 32'd0);
    chk("rd_ren_idle", 32'(ren_ext_2), 32'd0);

    // Mixed load, timeout at limit 20, start ignored in RUN
    start = 1'b1; tick(); start = 1'b0;
    chk("reload_cpu_rst", 32'(cpu_rst_n), 32'd0);
    chk("reload_done", 32'(done), 32'd0);
    chk("reload_count", cycle_count, 32'd0);
    load_beat(1'b0, 32'h11111111, 1'b0, 32'd0);
    load_beat(1'b1, 32'h0BADF00D, 1'b0, 32'd0);
    load_beat(1'b0, 32'h33333333, 1'b1, 32'd4);
    cycle_limit = 32'd20;
    tick();
    chk("lim_enable", 32'(cpu_enable), 32'd1);
    repeat (4) tick();
    start = 1'b1; tick(); start = 1'b0;
    chk("run_start_busy", 32'(busy), 32'd1);
    chk("run_start_enable", 32'(cpu_enable), 32'd1);
    chk("run_start_ready", 32'(ld_ready), 32'd0);
    repeat (14) tick();
    chk("lim_pre_timeout", 32'(timeout), 32'd0);
    chk("lim_pre_count", cycle_count, 32'd19);
    tick();
    chk("lim_timeout", 32'(timeout), 32'd1);
    chk("lim_drain_enable", 32'(cpu_enable), 32'd1);
    repeat (4) tick();
    chk("lim_done", 32'(done), 32'd1);
    chk("lim_enable_off", 32'(cpu_enable), 32'd0);
    chk("lim_count", cycle_count, 32'd24);
    chk("lim_timeout_hold", 32'(timeout), 32'd1);

    rd_addr = 32'h0; rd_req = 1'b1; tick(); rd_req = 1'b0; tick();
    chk("rd0_valid", 32'(rd_valid), 32'd1);
    chk("rd0_data", rd_data, 32'h0BADF00D);

    // Halt coincides with the limit cycle; halt held into DRAIN is ignored
    start = 1'b1; tick(); start = 1'b0;
    chk("t3_timeout_clr", 32'(timeout), 32'd0);
    load_beat(1'b0, 32'h00000000, 1'b1, 32'd0);
    tick();
    repeat (19) tick();
    halt = 1'b1; tick();
    chk("both_timeout", 32'(timeout), 32'd0);
    chk("both_enable", 32'(cpu_enable), 32'd1);
    tick(); halt = 1'b0;
    repeat (2) tick();
    chk("both_drain", 32'(cpu_enable), 32'd1);
    chk("both_not_done", 32'(done), 32'd0);
    tick();
    chk("both_done", 32'(done), 32'd1);
    chk("both_enable_off", 32'(cpu_enable), 32'd0);
    chk("both_timeout_end", 32'(timeout), 32'd0);
    chk("both_count", cycle_count, 32'd24);

    // Reset asserted mid-RUN
    cycle_limit = 32'd0;
    start = 1'b1; tick(); start = 1'b0;
    load_beat(1'b1, 32'h00000011, 1'b1, 32'd0);
    tick();
    repeat (3) tick();
    chk("pre_rst_enable", 32'(cpu_enable), 32'd1);
    arst_n = 1'b0; #1;
    chk_all_zero("mid_rst");
    tick();
    arst_n = 1'b1;
    tick();
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_cpu_rst", 32'(cpu_rst_n), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run controller that sequences the pipelined CPU through program load, execution, pipeline drain and result readback. It sits between the host/testbench and the CPU top level. It drives the CPU's external instruction-memory and data-memory ports, its `enable` input and a CPU-side reset. It also counts executed cycles and enforces an optional cycle budget.

## Interface
Parameters:
- `IMEM_ADDR_W`, 9: instruction memory word-address width.
- `DMEM_ADDR_W`, 10: data memory word-address width.
- `DRAIN_CYCLES`, 4: cycles `cpu_enable` stays high after halt so in-flight instructions reach writeback.
- `RD_LAT`, 1: data-memory external read latency in cycles.

Ports:
- `clk` in 1: single clock.
- `arst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a load; honoured in IDLE and DONE only.
- `ld_valid` in 1, `ld_ready` out 1: load-beat handshake.
- `ld_data` in 32: load word.
- `ld_dst` in 1: destination, 0 = imem, 1 = dmem.
- `ld_last` in 1: final beat.
- `halt` in 1: CPU halt detected (decode-stage pulse).
- `cycle_limit` in 32: RUN budget; 0 = unlimited.
- `rd_req` in 1, `rd_addr` in 32: dmem readback request (DONE only).
- `rd_valid` out 1, `rd_data` out 32: readback response.
- `rdata_ext_2` in 32: CPU data-memory external read data.
- `addr_ext`, `wdata_ext` out 32; `wen_ext`, `ren_ext` out 1: CPU imem external port.
- `addr_ext_2`, `wdata_ext_2` out 32; `wen_ext_2`, `ren_ext_2` out 1: CPU dmem external port.
- `cpu_enable` out 1: CPU `enable`.
- `cpu_rst_n` out 1: CPU reset.
- `busy`, `done`, `timeout` out 1: status.
- `cycle_count` out 32: RUN+DRAIN cycles elapsed.

## Operation
- States: IDLE, LOAD, RUN, DRAIN, DONE. Reset → IDLE from any state, mid-operation included.
- Reset values: all outputs 0, including `cpu_rst_n` (CPU held in reset).
- IDLE: `start` → LOAD. The transition clears both address counters, `cycle_count` and `timeout`.
- LOAD:
  - `ld_ready` = 1.
  - Each accepted beat (`ld_valid & ld_ready`) writes `ld_data` to the memory chosen by `ld_dst`, at byte address counter×4. Only that memory's counter increments.
  - Counters wrap modulo 2^ADDR_W words, with no error.
  - Accepting `ld_last` drops `ld_ready` and moves to RUN.
- RUN:
  - `cpu_rst_n` = 1, `cpu_enable` = 1, `cycle_count` += 1 per cycle.
  - `halt` → DRAIN.
  - `cycle_limit != 0 && cycle_count == cycle_limit-1` → DRAIN with `timeout` set.
  - Simultaneous `halt` and limit: halt wins, `timeout` stays 0.
- DRAIN: `cpu_enable` stays 1 for exactly `DRAIN_CYCLES` cycles, counting continues, then DONE. `halt` is ignored.
- DONE:
  - `cpu_enable` = 0, `cpu_rst_n` stays 1 (state preserved), `done` = 1.
  - `rd_req` drives `ren_ext_2` = 1 and `addr_ext_2` = `rd_addr` for one cycle. `rd_valid` pulses `RD_LAT` cycles later with `rd_data` = `rdata_ext_2`.
  - One read outstanding; `rd_req` is ignored while pending.
  - `start` → LOAD, with `cpu_rst_n` driven 0 again.
- `busy` = LOAD|RUN|DRAIN. `start` in those states is ignored.
- External `wen`/`ren` are 0 outside LOAD/DONE. `ren_ext` is always 0.

## Timing
- All outputs are registered.
- Beat accepted at edge k → `wen_ext`/`wen_ext_2`, address and data valid for exactly cycle k..k+1. Back-to-back beats give one write per cycle.
- `ld_last` accepted at edge k: its write occurs in cycle k..k+1. `cpu_rst_n` and `cpu_enable` rise at edge k+1, when the state enters RUN.
- `halt` sampled at edge h → DRAIN from h. `cpu_enable` falls at edge h+DRAIN_CYCLES; `done` rises at the same edge.
- `cycle_count` saturates at 2^32-1.

## Structure
- Package `cpu_ctrl_pkg`: state enumeration, `DRAIN_CYCLES_DEF`, `RD_LAT_DEF`, and the `LD_DST_IMEM`/`LD_DST_DMEM` constants.
- One sub-module, `run_counter`: 32-bit saturating counter with clear, enable and a `limit_hit` compare output.
- Existing `reg_arstn_en` is reused for the output registers.

## Test plan
- Load three imem beats (0x20010005, 0x20020007, 0x00221820) with ld_dst=0, the last with ld_last → `addr_ext` 0,4,8 on consecutive cycles; `cpu_enable` rises the cycle after the third write.
- Mixed load (imem, dmem, imem) → `addr_ext` 0,4 and `addr_ext_2` 0; each counter is independent.
- RUN with cycle_limit=0, `halt` pulsed at cycle 10 → `cpu_enable` low 4 cycles later, `done`=1, `timeout`=0, `cycle_count`=14.
- cycle_limit=20 with no halt → `timeout`=1 and DRAIN entered after 20 RUN cycles. Repeat with `halt` on the limit cycle → `timeout`=0.
- DONE, `rd_req` at rd_addr=0x10 with memory holding 0xDEADBEEF → `ren_ext_2` pulse, then `rd_valid` 1 cycle later with `rd_data`=0xDEADBEEF. A second `rd_req` while pending is ignored.
- `arst_n` asserted mid-RUN → IDLE with all outputs 0. `start` during RUN → no effect.
